// File: rtl/i2c_target_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_rx
// Brief    : Write-only I2C target receiver. Oversamples SCL/SDA on clk2,
//            decodes START/STOP, matches a 7-bit address, ACKs, and
//            deserialises each following byte with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_rx #(
  parameter logic [6:0] ADDR7   = 7'h3D,
  parameter logic [3:0] MAX_IDX = 4'd15
) (
  input  logic       clk2,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_pull,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [3:0] rx_index,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  // Synchroniser and history flops; idle bus is high.
  logic r_scl_meta, r_scl_sync, r_scl_hist;
  logic r_sda_meta, r_sda_sync, r_sda_hist;

  state_t     r_state,   w_state_nx;
  logic [3:0] r_bitcnt,  w_bitcnt_nx;   // bit 3 set = all 8 bits shifted in
  logic [7:0] r_shift,   w_shift_nx;
  logic       r_sda_pull, w_pull_nx;
  logic [7:0] r_rx_data, w_data_nx;
  logic       r_rx_valid, w_valid_nx;
  logic [3:0] r_rx_index, w_idx_nx;
  logic       r_busy,    w_busy_nx;
  logic       r_stop_det, w_stopdet_nx;

  logic w_scl_rise, w_scl_fall, w_scl_edge;
  logic w_start, w_stop, w_addr_match;

  // Bring the asynchronous bus lines into the clk2 domain and keep one sample of history.
  always_ff @(posedge clk2) begin
    if (!reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_meta <= scl;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= sda;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
    end
  end

  // An SCL edge masks any simultaneous SDA change, so START/STOP need SCL steady high.
  assign w_scl_rise   = r_scl_sync & ~r_scl_hist;
  assign w_scl_fall   = ~r_scl_sync & r_scl_hist;
  assign w_scl_edge   = w_scl_rise | w_scl_fall;
  assign w_start      = r_scl_sync & ~w_scl_edge & ~r_sda_sync & r_sda_hist;
  assign w_stop       = r_scl_sync & ~w_scl_edge & r_sda_sync & ~r_sda_hist;
  assign w_addr_match = (r_shift[7:1] == ADDR7) && !r_shift[0];

  // State and output registers.
  always_ff @(posedge clk2) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 4'd0;
      r_shift    <= 8'h00;
      r_sda_pull <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_index <= 4'd0;
      r_busy     <= 1'b0;
      r_stop_det <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bitcnt   <= w_bitcnt_nx;
      r_shift    <= w_shift_nx;
      r_sda_pull <= w_pull_nx;
      r_rx_data  <= w_data_nx;
      r_rx_valid <= w_valid_nx;
      r_rx_index <= w_idx_nx;
      r_busy     <= w_busy_nx;
      r_stop_det <= w_stopdet_nx;
    end
  end

  // Next-state logic: STOP beats START, which beats the per-bit protocol.
  always_comb begin
    w_state_nx   = r_state;
    w_bitcnt_nx  = r_bitcnt;
    w_shift_nx   = r_shift;
    w_pull_nx    = r_sda_pull;
    w_data_nx    = r_rx_data;
    w_valid_nx   = 1'b0;
    w_idx_nx     = r_rx_index;
    w_busy_nx    = r_busy;
    w_stopdet_nx = 1'b0;

    if (w_stop) begin
      w_state_nx   = ST_IDLE;
      w_pull_nx    = 1'b0;
      w_busy_nx    = 1'b0;
      w_idx_nx     = 4'd0;
      w_stopdet_nx = 1'b1;
    end else if (w_start) begin
      w_state_nx  = ST_ADDR;
      w_pull_nx   = 1'b0;
      w_busy_nx   = 1'b0;
      w_idx_nx    = 4'd0;
      w_bitcnt_nx = 4'd7;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pull_nx = 1'b0;
        end
        ST_ADDR: begin
          if (w_scl_rise && !r_bitcnt[3]) begin
            w_shift_nx  = {r_shift[6:0], r_sda_sync};
            w_bitcnt_nx = r_bitcnt - 4'd1;
          end else if (w_scl_fall && r_bitcnt[3]) begin
            if (w_addr_match) begin
              w_pull_nx  = 1'b1;
              w_busy_nx  = 1'b1;
              w_state_nx = ST_ADDR_ACK;
            end else begin
              w_pull_nx  = 1'b0;
              w_state_nx = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_pull_nx   = 1'b0;
            w_bitcnt_nx = 4'd7;
            w_state_nx  = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_scl_rise && !r_bitcnt[3]) begin
            w_shift_nx  = {r_shift[6:0], r_sda_sync};
            w_bitcnt_nx = r_bitcnt - 4'd1;
          end else if (w_scl_fall && r_bitcnt[3]) begin
            w_data_nx  = r_shift;
            w_valid_nx = 1'b1;
            w_pull_nx  = 1'b1;
            w_state_nx = ST_DATA_ACK;
          end
        end
        ST_DATA_ACK: begin
          if (w_scl_fall) begin
            w_pull_nx   = 1'b0;
            w_bitcnt_nx = 4'd7;
            w_state_nx  = ST_DATA;
            if (r_rx_index != MAX_IDX) begin
              w_idx_nx = r_rx_index + 4'd1;
            end
          end
        end
        ST_IGNORE: begin
          w_pull_nx = 1'b0;
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_pull_nx  = 1'b0;
        end
      endcase
    end
  end

  // Reset releases SDA combinationally so the bus is freed without waiting for an edge.
  assign sda_pull = r_sda_pull & reset;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_index = r_rx_index;
  assign busy     = r_busy;
  assign stop_det = r_stop_det;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_rx
// Brief    : Directed bench for i2c_target_rx; bit-banged I2C master with
//            SCL = clk2/16 and a queue of expected received bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_rx;

  logic       clk2  = 1'b0;
  logic       reset = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_pull;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_index;
  logic       busy;
  logic       stop_det;
  logic       w_sda_bus;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_stop   = 0;
  logic [11:0] sb_q[$];

  // Open-drain bus: either side can pull SDA low.
  assign w_sda_bus = m_sda & ~sda_pull;

  i2c_target_rx #(.ADDR7(7'h3D), .MAX_IDX(4'd15)) dut (
    .clk2     (clk2),
    .reset    (reset),
    .scl      (m_scl),
    .sda      (w_sda_bus),
    .sda_pull (sda_pull),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_index (rx_index),
    .busy     (busy),
    .stop_det (stop_det)
  );

  always #5 clk2 = ~clk2;

  initial begin
    #2000000;
    $display("FAIL timeout: observed no end of sequence, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid must match the oldest queued byte.
  always @(negedge clk2) begin
    if (reset === 1'b1) begin
      if (stop_det === 1'b1) n_stop++;
      if (rx_valid === 1'b1) begin
        check("valid_with_stop", {31'd0, stop_det}, 32'd0);
        check("rx_valid_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
          logic [11:0] e;
          e = sb_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
          check("rx_index", {28'd0, rx_index}, {28'd0, e[11:8]});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk2);
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] idx);
    sb_q.push_back({idx, d});
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    tick(4);
    m_scl = 1'b1;
    tick(8);
    m_scl = 1'b0;
    tick(4);
  endtask

  task automatic ack_slot(input string tag, input logic exp);
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(4);
    check(tag, {31'd0, sda_pull}, {31'd0, exp});
    tick(4);
    m_scl = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_slot(tag, exp_ack);
  endtask

  // Works both from an idle bus and as a repeated START with SCL low.
  task automatic bus_start();
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(4);
    m_sda = 1'b0;
    tick(4);
    m_scl = 1'b0;
    tick(4);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    tick(4);
    m_scl = 1'b1;
    tick(4);
    m_sda = 1'b1;
    tick(8);
  endtask

  initial begin
    int s0;
    logic [3:0] exp_idx;

    // Reset state
    reset = 1'b0;
    tick(4);
    check("rst_sda_pull", {31'd0, sda_pull}, 32'd0);
    check("rst_rx_data",  {24'd0, rx_data},  32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_index", {28'd0, rx_index}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_stop_det", {31'd0, stop_det}, 32'd0);
    reset = 1'b1;
    tick(4);

    // Basic write: address, mode byte, one data byte
    s0 = n_stop;
    bus_start();
    send_byte(8'h7A, 1'b1, "t1_addr_ack");
    push(8'h00, 4'd0);
    send_byte(8'h00, 1'b1, "t1_mode_ack");
    check("t1_busy", {31'd0, busy}, 32'd1);
    push(8'hA5, 4'd1);
    send_byte(8'hA5, 1'b1, "t1_data_ack");
    bus_stop();
    tick(4);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_stop_count", n_stop - s0, 32'd1);
    check("t1_queue_empty", sb_q.size(), 32'd0);
    check("t1_rx_data_hold", {24'd0, rx_data}, 32'hA5);

    // Wrong address
    s0 = n_stop;
    bus_start();
    send_byte(8'h7C, 1'b0, "t2_addr_nack");
    check("t2_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h55, 1'b0, "t2_data_nack");
    bus_stop();
    tick(4);
    check("t2_stop_count", n_stop - s0, 32'd1);
    check("t2_queue_empty", sb_q.size(), 32'd0);

    // Read request is not acknowledged and later bytes are ignored
    bus_start();
    send_byte(8'h7B, 1'b0, "t3_read_nack");
    send_byte(8'h12, 1'b0, "t3_byte1_nack");
    send_byte(8'h34, 1'b0, "t3_byte2_nack");
    check("t3_busy", {31'd0, busy}, 32'd0);
    bus_stop();
    tick(4);
    check("t3_queue_empty", sb_q.size(), 32'd0);

    // Repeated START drops the partial byte
    bus_start();
    send_byte(8'h7A, 1'b1, "t4_addr1_ack");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_start();
    check("t4_busy_after_rstart", {31'd0, busy}, 32'd0);
    send_byte(8'h7A, 1'b1, "t4_addr2_ack");
    push(8'h3C, 4'd0);
    send_byte(8'h3C, 1'b1, "t4_data_ack");
    bus_stop();
    tick(4);
    check("t4_queue_empty", sb_q.size(), 32'd0);

    // Index saturation over 20 bytes
    bus_start();
    send_byte(8'h7A, 1'b1, "t5_addr_ack");
    exp_idx = 4'd0;
    for (int i = 0; i < 20; i++) begin
      push(8'(i), exp_idx);
      send_byte(8'(i), 1'b1, "t5_data_ack");
      if (exp_idx != 4'd15) exp_idx = exp_idx + 4'd1;
    end
    check("t5_index_saturated", {28'd0, rx_index}, 32'd15);
    bus_stop();
    tick(4);
    check("t5_index_after_stop", {28'd0, rx_index}, 32'd0);
    check("t5_queue_empty", sb_q.size(), 32'd0);

    // Reset during bit 4 of a data byte (8'hF5)
    bus_start();
    send_byte(8'h7A, 1'b1, "t6_addr_ack");
    push(8'h01, 4'd0);
    send_byte(8'h01, 1'b1, "t6_mode_ack");
    check("t6_index_before_rst", {28'd0, rx_index}, 32'd1);
    check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    m_sda = 1'b1;
    tick(4);
    m_scl = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(1);
    check("t6_rst_sda_pull", {31'd0, sda_pull}, 32'd0);
    check("t6_rst_rx_index", {28'd0, rx_index}, 32'd0);
    check("t6_rst_busy",     {31'd0, busy},     32'd0);
    check("t6_rst_rx_data",  {24'd0, rx_data},  32'd0);
    tick(1);
    reset = 1'b1;
    tick(3);
    m_scl = 1'b0;
    tick(4);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ack_slot("t6_ignored_nack", 1'b0);
    bus_stop();
    tick(4);
    check("t6_queue_empty_after_rst", sb_q.size(), 32'd0);
    bus_start();
    send_byte(8'h7A, 1'b1, "t6_addr2_ack");
    push(8'h11, 4'd0);
    send_byte(8'h11, 1'b1, "t6_data2_ack");
    bus_stop();
    tick(4);
    check("t6_final_rx_data", {24'd0, rx_data}, 32'h11);
    check("t6_queue_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
